// File: rtl/poly_eval_accelerator_if.sv
// Result/status bundle driven by the polynomial evaluation accelerator.
interface poly_eval_accelerator_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [1:0]       status;
  logic             halted;

  modport master (output sum, output result, output result_valid, output status, output halted);
  modport slave  (input  sum, input  result, input  result_valid, input  status, input  halted);
endinterface

// File: rtl/poly_eval_accelerator.sv
// Polynomial evaluation accelerator: ROM-fed instruction/data FIFOs and a
// Horner-method core that reports one result per EVAL.

// Synchronous FIFO with registered read port; power-of-two depth.
module poly_eval_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr_c;
  logic             do_rd_c;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign do_rd_c = rd_en && !empty_c;
  // A write into a full FIFO is accepted only when a read frees a slot.
  assign do_wr_c = wr_en && (!full_c || do_rd_c);

  // Storage array; contents are only observed after being written.
  always_ff @(posedge clock) begin
    if (do_wr_c) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd_c) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr_c, do_rd_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module poly_eval_accelerator #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned IROM_LEN   = 4,
  parameter int unsigned DROM_LEN   = 9,
  // Entry 0 sits in the least significant WIDTH bits.
  parameter logic [IROM_LEN*WIDTH-1:0] IROM = {
    {2'b11, (WIDTH-2)'(0)},
    {2'b01, (WIDTH-6)'(0), 4'd0},
    {2'b01, (WIDTH-6)'(0), 4'd1},
    {2'b01, (WIDTH-6)'(0), 4'd2}
  },
  parameter logic [DROM_LEN*WIDTH-1:0] DROM = {
    WIDTH'(6), WIDTH'(9), WIDTH'(7), WIDTH'(4), WIDTH'(5),
    WIDTH'(1), WIDTH'(2), WIDTH'(3), WIDTH'(2)
  }
) (
  input  logic                    clock,
  input  logic                    reset,
  poly_eval_accelerator_if.master io
);
  localparam int unsigned IPW = $clog2(IROM_LEN + 1);
  localparam int unsigned DPW = $clog2(DROM_LEN + 1);
  localparam int unsigned CNW = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD_X, S_ACCUM, S_WRITE, S_HALTED
  } state_t;

  state_t           state_q, state_n;
  logic [IPW-1:0]   iptr_q;
  logic [DPW-1:0]   dptr_q;
  logic             ins_wr_c, dat_wr_c;
  logic             ins_rd_c, dat_rd_c;
  logic [WIDTH-1:0] ins_rdata, dat_rdata;
  logic             ins_full_c, ins_empty_c, dat_full_c, dat_empty_c;
  logic [1:0]       op_c;
  logic             unused_ins_bits_c;

  logic [3:0]       deg_q;
  logic             ill_q;
  logic             pend_q;
  logic [CNW-1:0]   cnt_q, req_q;
  logic [WIDTH-1:0] x_q, sum_q, result_q;
  logic             rv_q, halted_q;
  logic [1:0]       status_q;

  assign ins_wr_c = (iptr_q != IPW'(IROM_LEN)) && !ins_full_c;
  assign dat_wr_c = (dptr_q != DPW'(DROM_LEN)) && !dat_full_c;
  assign op_c     = ins_rdata[WIDTH-1 -: 2];
  assign unused_ins_bits_c = ^ins_rdata[WIDTH-3:4];

  poly_eval_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_ins_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (ins_wr_c),
    .wr_data (IROM[int'(iptr_q)*WIDTH +: WIDTH]),
    .rd_en   (ins_rd_c),
    .rd_data (ins_rdata),
    .full_c  (ins_full_c),
    .empty_c (ins_empty_c)
  );

  poly_eval_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (dat_wr_c),
    .wr_data (DROM[int'(dptr_q)*WIDTH +: WIDTH]),
    .rd_en   (dat_rd_c),
    .rd_data (dat_rdata),
    .full_c  (dat_full_c),
    .empty_c (dat_empty_c)
  );

  // ROM sources: stream each ROM once into its FIFO, pausing while full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      iptr_q <= '0;
      dptr_q <= '0;
    end else begin
      if (ins_wr_c) iptr_q <= iptr_q + IPW'(1);
      if (dat_wr_c) dptr_q <= dptr_q + DPW'(1);
    end
  end

  // Core state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // Core next-state and FIFO read requests.
  always_comb begin
    state_n  = state_q;
    ins_rd_c = 1'b0;
    dat_rd_c = 1'b0;
    case (state_q)
      S_IDLE:  state_n = S_FETCH;
      S_FETCH: begin
        if (!ins_empty_c) begin
          ins_rd_c = 1'b1;
          state_n  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_c)
          2'b01:   state_n = S_LOAD_X;
          2'b10:   state_n = S_WRITE;
          2'b11:   state_n = S_HALTED;
          default: state_n = S_FETCH;
        endcase
      end
      // First cycle requests x, the following cycle captures it.
      S_LOAD_X: begin
        if (pend_q)            state_n  = S_ACCUM;
        else if (!dat_empty_c) dat_rd_c = 1'b1;
      end
      // Coefficient reads are pipelined one per cycle while any remain.
      S_ACCUM: begin
        if ((req_q != '0) && !dat_empty_c) dat_rd_c = 1'b1;
        if (pend_q && (cnt_q == CNW'(1)))  state_n  = S_WRITE;
      end
      S_WRITE:  state_n = S_FETCH;
      S_HALTED: state_n = S_HALTED;
      default:  state_n = S_IDLE;
    endcase
  end

  // Horner datapath and registered result/status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deg_q    <= '0;
      ill_q    <= 1'b0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      req_q    <= '0;
      x_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      status_q <= 2'b00;
      halted_q <= 1'b0;
    end else begin
      pend_q <= dat_rd_c;
      rv_q   <= 1'b0;
      case (state_q)
        S_DECODE: begin
          deg_q <= ins_rdata[3:0];
          ill_q <= (op_c == 2'b10);
          if (op_c == 2'b11) begin
            halted_q <= 1'b1;
            status_q <= 2'b11;
            rv_q     <= 1'b1;
          end
        end
        S_LOAD_X: begin
          if (pend_q) begin
            x_q   <= dat_rdata;
            sum_q <= '0;
            cnt_q <= CNW'(deg_q) + CNW'(1);
            req_q <= CNW'(deg_q) + CNW'(1);
          end
        end
        S_ACCUM: begin
          if (dat_rd_c) req_q <= req_q - CNW'(1);
          if (pend_q) begin
            sum_q <= sum_q * x_q + dat_rdata;
            cnt_q <= cnt_q - CNW'(1);
          end
        end
        S_WRITE: begin
          rv_q <= 1'b1;
          if (ill_q) begin
            status_q <= 2'b10;
          end else begin
            result_q <= sum_q;
            status_q <= 2'b01;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.sum          = sum_q;
  assign io.result       = result_q;
  assign io.result_valid = rv_q;
  assign io.status       = status_q;
  assign io.halted       = halted_q;
endmodule

// File: tb/tb_poly_eval_accelerator.sv
// Bench for poly_eval_accelerator: built-in program, two alternate ROM
// programs, asynchronous reset mid-run, and a standalone FIFO check.
`timescale 1ns/1ps
module tb_poly_eval_accelerator;
  typedef struct packed {
    logic [15:0] result;
    logic [1:0]  status;
  } ev_t;

  localparam int NI      = 3;
  localparam int MAXEV   = 16;
  localparam int RUN_CYC = 45;

  localparam logic [31:0] W1_IROM = {16'hC000, 16'h4001};
  localparam logic [47:0] W1_DROM = {16'h0003, 16'h0100, 16'h0100};
  localparam logic [63:0] W2_IROM = {16'hC000, 16'h8000, 16'h0000, 16'h4000};
  localparam logic [31:0] W2_DROM = {16'h1234, 16'h0055};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  ev_t exp_a [NI][MAXEV];
  int  exp_n [NI];
  ev_t got_a [NI][MAXEV];
  int  got_c [NI][MAXEV];
  int  got_n [NI];

  poly_eval_accelerator_if #(.WIDTH(16)) if0 ();
  poly_eval_accelerator_if #(.WIDTH(16)) if1 ();
  poly_eval_accelerator_if #(.WIDTH(16)) if2 ();

  poly_eval_accelerator u_main (.clock(clock), .reset(reset), .io(if0));
  poly_eval_accelerator #(.IROM_LEN(2), .DROM_LEN(3), .IROM(W1_IROM), .DROM(W1_DROM))
    u_wrap (.clock(clock), .reset(reset), .io(if1));
  poly_eval_accelerator #(.IROM_LEN(4), .DROM_LEN(2), .IROM(W2_IROM), .DROM(W2_DROM))
    u_misc (.clock(clock), .reset(reset), .io(if2));

  logic [15:0] o_sum [NI];
  logic [15:0] o_res [NI];
  logic        o_rv  [NI];
  logic [1:0]  o_st  [NI];
  logic        o_hlt [NI];
  assign o_sum[0] = if0.sum;  assign o_res[0] = if0.result;  assign o_rv[0] = if0.result_valid;
  assign o_st[0]  = if0.status; assign o_hlt[0] = if0.halted;
  assign o_sum[1] = if1.sum;  assign o_res[1] = if1.result;  assign o_rv[1] = if1.result_valid;
  assign o_st[1]  = if1.status; assign o_hlt[1] = if1.halted;
  assign o_sum[2] = if2.sum;  assign o_res[2] = if2.result;  assign o_rv[2] = if2.result_valid;
  assign o_st[2]  = if2.status; assign o_hlt[2] = if2.halted;

  logic        f_wr = 1'b0;
  logic        f_rd = 1'b0;
  logic [15:0] f_wdata = '0;
  logic [15:0] f_rdata;
  logic        f_full, f_empty;

  poly_eval_fifo #(.WIDTH(16), .DEPTH(8)) u_fifo (
    .clock(clock), .reset(reset), .wr_en(f_wr), .wr_data(f_wdata),
    .rd_en(f_rd), .rd_data(f_rdata), .full_c(f_full), .empty_c(f_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input int k, input logic [15:0] r, input logic [1:0] s);
    exp_a[k][exp_n[k]] = '{result: r, status: s};
    exp_n[k]++;
  endfunction

  // Reference: run the program straight from the ROM lists with plain arithmetic.
  function automatic void build_model(input int k, input logic [255:0] ip, input int il,
                                      input logic [255:0] dp);
    logic [15:0] w, x, s, res;
    int d;
    res = '0;
    d = 0;
    exp_n[k] = 0;
    for (int i = 0; i < il; i++) begin
      w = ip[i*16 +: 16];
      if (w[15:14] == 2'b11) begin
        push_exp(k, res, 2'b11);
        break;
      end else if (w[15:14] == 2'b10) begin
        push_exp(k, res, 2'b10);
      end else if (w[15:14] == 2'b01) begin
        x = dp[d*16 +: 16];
        d++;
        s = '0;
        for (int j = 0; j <= int'(w[3:0]); j++) begin
          s = 16'(32'(s) * 32'(x) + 32'(dp[d*16 +: 16]));
          d++;
        end
        res = s;
        push_exp(k, res, 2'b01);
      end
    end
  endfunction

  // Drop reset, check outputs clear at once, hold for a few cycles, release at a negedge.
  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_sum%0d", k),    32'(o_sum[k]), 32'd0);
      chk($sformatf("rst_result%0d", k), 32'(o_res[k]), 32'd0);
      chk($sformatf("rst_valid%0d", k),  32'(o_rv[k]),  32'd0);
      chk($sformatf("rst_status%0d", k), 32'(o_st[k]),  32'd0);
      chk($sformatf("rst_halted%0d", k), 32'(o_hlt[k]), 32'd0);
    end
    repeat (hold) @(negedge clock);
    reset = 1'b1;
  endtask

  // Run from reset release, log every result_valid pulse, compare with expectations.
  task automatic run_and_check(input string tag);
    logic        prev [NI];
    logic        seen [NI];
    logic [15:0] hsum [NI];
    for (int k = 0; k < NI; k++) begin
      got_n[k] = 0; prev[k] = 1'b0; seen[k] = 1'b0; hsum[k] = '0;
    end
    for (int c = 1; c <= RUN_CYC; c++) begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) begin
        if (o_rv[k]) begin
          chk($sformatf("%s_pulse_width%0d", tag, k), 32'(prev[k]), 32'd0);
          if (got_n[k] < MAXEV) begin
            got_a[k][got_n[k]] = '{result: o_res[k], status: o_st[k]};
            got_c[k][got_n[k]] = c;
          end
          got_n[k]++;
        end
        prev[k] = o_rv[k];
        if (o_hlt[k] && !seen[k]) begin
          seen[k] = 1'b1;
          hsum[k] = o_sum[k];
        end
      end
    end
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_num_pulses%0d", tag, k), 32'(got_n[k]), 32'(exp_n[k]));
      for (int j = 0; j < exp_n[k] && j < got_n[k] && j < MAXEV; j++) begin
        chk($sformatf("%s_result%0d_%0d", tag, k, j), 32'(got_a[k][j].result), 32'(exp_a[k][j].result));
        chk($sformatf("%s_status%0d_%0d", tag, k, j), 32'(got_a[k][j].status), 32'(exp_a[k][j].status));
      end
      chk($sformatf("%s_final_halted%0d", tag, k), 32'(o_hlt[k]), 32'd1);
      chk($sformatf("%s_final_status%0d", tag, k), 32'(o_st[k]), 32'd3);
      chk($sformatf("%s_sum_stable%0d", tag, k), 32'(o_sum[k]), 32'(hsum[k]));
    end
    if (got_n[0] > 0)
      chk($sformatf("%s_first_eval_by_12", tag), 32'(got_c[0][0] <= 12), 32'd1);
    if (got_n[0] == exp_n[0] && exp_n[0] > 0)
      chk($sformatf("%s_halt_by_40", tag), 32'(got_c[0][exp_n[0]-1] <= 40), 32'd1);
  endtask

  task automatic fcyc(input logic w, input logic [15:0] d, input logic r);
    f_wr = w; f_wdata = d; f_rd = r;
    @(negedge clock);
    f_wr = 1'b0; f_rd = 1'b0;
  endtask

  initial begin
    logic [15:0] mq [$];
    logic [15:0] m_rd;
    logic        w, r, dr, dw;
    int          hit;

    // Expected events of the built-in program.
    exp_n[0] = 0;
    push_exp(0, 16'd17, 2'b01);
    push_exp(0, 16'd27, 2'b01);
    push_exp(0, 16'd6,  2'b01);
    push_exp(0, 16'd6,  2'b11);
    build_model(1, 256'(W1_IROM), 2, 256'(W1_DROM));
    build_model(2, 256'(W2_IROM), 4, 256'(W2_DROM));

    #3;
    do_reset(1);
    run_and_check("boot");

    // Reset while the first EVAL is accumulating.
    do_reset(1);
    hit = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge clock);
      if (o_sum[0] != 16'd0) hit = 1;
    end
    chk("accum_reached", 32'(hit), 32'd1);
    do_reset(1);
    run_and_check("mid_accum");

    // Resets at random points with random low time.
    for (int it = 0; it < 3; it++) begin
      do_reset(int'($urandom_range(1, 3)));
      repeat ($urandom_range(1, 30)) @(negedge clock);
      do_reset(int'($urandom_range(1, 3)));
      run_and_check($sformatf("rand%0d", it));
    end

    // FIFO: fill, overflow, drain, read on empty.
    for (int i = 0; i < 8; i++) fcyc(1'b1, 16'hA000 + 16'(i), 1'b0);
    chk("fifo_full_after8", 32'(f_full), 32'd1);
    fcyc(1'b1, 16'hBEEF, 1'b0);
    chk("fifo_full_after9", 32'(f_full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      fcyc(1'b0, 16'h0, 1'b1);
      chk($sformatf("fifo_read%0d", i), 32'(f_rdata), 32'(16'hA000 + 16'(i)));
    end
    chk("fifo_empty_after_drain", 32'(f_empty), 32'd1);
    fcyc(1'b0, 16'h0, 1'b1);
    chk("fifo_read_empty_data", 32'(f_rdata), 32'h0000A007);
    chk("fifo_read_empty_flag", 32'(f_empty), 32'd1);
    fcyc(1'b1, 16'h5A5A, 1'b0);
    fcyc(1'b0, 16'h0, 1'b1);
    chk("fifo_after_empty_read", 32'(f_rdata), 32'h00005A5A);

    // FIFO: random traffic against a queue, alternating fill-biased and drain-biased phases.
    m_rd = 16'h5A5A;
    for (int i = 0; i < 160; i++) begin
      if ((i % 80) < 40) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f_wr = w; f_rd = r; f_wdata = 16'($urandom);
      dr = r && (mq.size() > 0);
      dw = w && ((mq.size() < 8) || dr);
      if (dr) m_rd = mq.pop_front();
      if (dw) mq.push_back(f_wdata);
      @(negedge clock);
      chk($sformatf("fifo_rand_data%0d", i),  32'(f_rdata), 32'(m_rd));
      chk($sformatf("fifo_rand_full%0d", i),  32'(f_full),  32'(mq.size() == 8));
      chk($sformatf("fifo_rand_empty%0d", i), 32'(f_empty), 32'(mq.size() == 0));
    end
    f_wr = 1'b0; f_rd = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/poly_eval_accelerator.md
Name:
poly_eval_accelerator

Overview:
- Self-contained polynomial evaluation accelerator: one core evaluates p(x) = a_N·x^N + … + a_0 by Horner's method.
- Two built-in source ROMs fill an instruction FIFO and a data FIFO after reset; the core consumes both FIFOs.
- Per-instruction results and status are presented on output ports.
- Top level of the accelerator subsystem; only clock and reset need to be driven, all other ports are outputs.

Parameters:
- WIDTH, 16, data, coefficient, x and sum width.
- FIFO_DEPTH, 8, entries per FIFO (power of two).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sum  output  WIDTH  core Horner accumulator.
- result  output  WIDTH  final sum of the last completed EVAL.
- result_valid  output  1  one-cycle pulse when result/status update.
- status  output  2  00 none, 01 EVAL done, 10 illegal opcode, 11 halted.
- halted  output  1  high once HALT executes; stays high until reset.

Behaviour:
- Reset (reset=0, asynchronous): FIFOs empty, ROM pointers 0, FSM IDLE; sum, result, result_valid, status, halted all 0. Reset mid-operation aborts everything; after release the program restarts at ROM entry 0.
- Instruction word (WIDTH bits):
  - [WIDTH-1:WIDTH-2] opcode: 01 EVAL, 11 HALT, 00 NOP, 10 illegal.
  - [3:0] degree N (0..15).
- Instruction ROM, 4 entries: EVAL N=2, EVAL N=1, EVAL N=0, HALT.
- Data ROM, 9 entries: 2,3,2,1, 5,4,7, 9,6.
- Data stream per EVAL: x first, then a_N down to a_0 (N+2 words).
- Sources: starting the first clock after reset release, each source writes one ROM entry per cycle into its FIFO while the FIFO is not full, then stops permanently.
- FIFOs:
  - Synchronous, registered out_data valid the cycle after a read enable.
  - Write when full is ignored; read when empty is ignored, with pointers and out_data unchanged.
  - Simultaneous read+write is allowed. When full, both take effect. When empty, only the write takes effect.
  - Pointers wrap modulo FIFO_DEPTH; count gives full/empty.
- Core FSM: IDLE → FETCH → DECODE → LOAD_X → ACCUM → WRITE → FETCH; HALTED is terminal.
  - IDLE: one cycle after reset release.
  - FETCH: assert instruction read when not empty; otherwise wait.
  - DECODE: latch the instruction.
    - EVAL: go to LOAD_X.
    - NOP: back to FETCH.
    - Illegal: WRITE with status 10, result unchanged.
    - HALT: set halted, status 11, pulse result_valid, enter HALTED.
  - LOAD_X: read one data word; latch x; sum←0; counter←N+1.
  - ACCUM: each available coefficient gives sum←(sum·x + a) mod 2^WIDTH (unsigned, truncated), counter decrements. At most one coefficient per cycle; reads may be pipelined back-to-back. Stall (no update) while the data FIFO is empty.
  - WRITE: result←sum, status←01, result_valid=1 for exactly this cycle; next FETCH.
- HALTED: no further FIFO reads; outputs hold; halted=1.
- Latency: with FIFOs supplied, the first EVAL (N=2) completes within 12 cycles of reset release. The whole built-in program completes within 40 cycles.
- An empty instruction FIFO never produces spurious result_valid.

Test Plan:
- reset=1 at t=0, low for one cycle, then high → all outputs 0 during low; program starts after release.
- Run from reset release → result_valid pulses with result=17 (status 01), then 27, then 6, in order, each pulse exactly one cycle.
- After the third result → status=11 and halted=1 within 40 cycles of release; no further result_valid pulses; sum stable.
- Assert reset during the ACCUM of the first EVAL → outputs clear immediately (asynchronously); after release the same sequence 17, 27, 6, HALT repeats.
- FIFO unit check: write 8 entries to a FIFO_DEPTH=8 FIFO; a 9th write is ignored. Read all entries back in order; a read on empty leaves out_data and pointers unchanged.
- Arithmetic wrap: EVAL N=1, x=0x0100, coefficients 0x0100 and 0x0003 → result 0x0003 (0x10000 truncates to 0).
